// File: rtl/double_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// double_buffer_ctrl
//
// Control for a two-bank ping-pong buffer. The producer fills the write bank
// one beat per cycle. When that bank is full and the read bank has been
// drained, the banks swap. The read side then streams the frame out through
// a valid/ready interface. The buffer memory lives outside this block; it has
// a 1-cycle read latency and holds rdata while ren is low.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      producer has a beat to write
//   in_ready      write bank can accept a beat
//   wen, wadr     buffer write strobe / address
//   ren, radr     buffer read strobe / address
//   switch_banks  1-cycle bank-swap pulse to the buffer
//   out_valid     buffer rdata holds a beat for the consumer
//   out_ready     consumer accepts the presented beat
//   out_last      presented beat is the last of its frame
//   frames_done   count of fully drained frames (wraps at 2^16)
// ---------------------------------------------------------------------------
module double_buffer_ctrl #(
   parameter int                       BANK_ADDR_WIDTH = 7,
   parameter logic [BANK_ADDR_WIDTH:0] BANK_DEPTH      = (BANK_ADDR_WIDTH+1)'(128)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_last,
   output logic                       wen,
   output logic [BANK_ADDR_WIDTH-1:0] wadr,
   output logic                       ren,
   output logic [BANK_ADDR_WIDTH-1:0] radr,
   output logic                       switch_banks,
   output logic [15:0]                frames_done
);

   localparam logic [BANK_ADDR_WIDTH:0] LAST_CNT = BANK_DEPTH - 1'b1;

   logic [BANK_ADDR_WIDTH:0] wcnt;
   logic [BANK_ADDR_WIDTH:0] rcnt;
   logic                     wfull;
   logic                     rbusy;
   logic                     out_hs;
   logic                     last_hs;

   assign in_ready     = !wfull;
   assign wen          = in_valid && in_ready;
   assign wadr         = wcnt[BANK_ADDR_WIDTH-1:0];

   // Swap only when a full frame is waiting and the reader is idle. Both
   // terms are registers, and the swap clears wfull, so this is a single-cycle
   // pulse. It cannot coincide with wen (wfull blocks writes) or with ren
   // (ren needs rbusy).
   assign switch_banks = wfull && !rbusy;

   // A new read is issued when the output register is empty or being emptied
   // this cycle, so one beat per cycle streams while out_ready stays high.
   assign ren          = rbusy && (rcnt < BANK_DEPTH) && (!out_valid || out_ready);
   assign radr         = rcnt[BANK_ADDR_WIDTH-1:0];

   // The presented beat comes from the most recent read, at address rcnt-1.
   // rcnt therefore reaches BANK_DEPTH exactly when the last beat is presented.
   assign out_last     = out_valid && rbusy && (rcnt == BANK_DEPTH);

   assign out_hs       = out_valid && out_ready;
   assign last_hs      = out_hs && out_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt        <= '0;
         wfull       <= 1'b0;
         rcnt        <= '0;
         rbusy       <= 1'b0;
         out_valid   <= 1'b0;
         frames_done <= '0;
      end else begin
         // write side
         if (wen) begin
            if (wcnt == LAST_CNT) begin
               wcnt  <= '0;
               wfull <= 1'b1;
            end else begin
               wcnt  <= wcnt + 1'b1;
            end
         end else if (switch_banks) begin
            wfull <= 1'b0;
         end

         // read side: the swap and last-beat handshake are mutually exclusive,
         // because last_hs needs rbusy=1 and the swap needs rbusy=0
         if (switch_banks) begin
            rbusy <= 1'b1;
            rcnt  <= '0;
         end else begin
            if (ren)
               rcnt <= rcnt + 1'b1;
            if (last_hs)
               rbusy <= 1'b0;
         end

         // output register
         if (ren)
            out_valid <= 1'b1;
         else if (out_hs)
            out_valid <= 1'b0;

         if (last_hs)
            frames_done <= frames_done + 16'd1;
      end
   end

endmodule

// File: doc/double_buffer_ctrl.md
DOUBLE_BUFFER_CTRL -- requirements
Module: double_buffer_ctrl

Interface
REQ-001 The block SHALL have parameter BANK_ADDR_WIDTH, default 7, giving the bank address width.
REQ-002 The block SHALL have parameter BANK_DEPTH, width BANK_ADDR_WIDTH+1, default 128, giving the entries per bank and per frame.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  SHALL indicate that the producer has a beat to write.
REQ-006 Port in_ready  output  1  SHALL indicate that the write bank can accept a beat.
REQ-007 Port out_valid  output  1  SHALL indicate that the buffer rdata holds a beat for the consumer.
REQ-008 Port out_ready  input  1  SHALL indicate that the consumer accepts the beat.
REQ-009 Port out_last  output  1  SHALL mark the final beat of a frame; it is meaningful only while out_valid=1.
REQ-010 Ports wen (output, 1) and wadr (output, BANK_ADDR_WIDTH) SHALL drive the buffer write port.
REQ-011 Ports ren (output, 1) and radr (output, BANK_ADDR_WIDTH) SHALL drive the buffer read port.
REQ-012 Port switch_banks  output  1  SHALL drive the buffer bank swap.
REQ-013 Port frames_done  output  16  SHALL count frames fully drained, wrapping modulo 2^16.

Function
REQ-014 State SHALL be: wcnt (write count), wfull (write bank full), rcnt (reads issued), rbusy (read bank holds an undrained frame), and the registered out_valid.
REQ-015 in_ready SHALL equal !wfull.
REQ-016 wen SHALL equal in_valid && in_ready.
REQ-017 wadr SHALL equal wcnt[BANK_ADDR_WIDTH-1:0].
REQ-018 On each wen, wcnt SHALL increment by 1.
REQ-019 On the wen with wcnt == BANK_DEPTH-1, wcnt SHALL become 0 and wfull SHALL become 1.
REQ-020 switch_banks SHALL equal wfull && !rbusy, derived combinationally from registers, so each assertion is a 1-cycle pulse.
REQ-021 On a switch_banks cycle, wfull SHALL become 0, rbusy SHALL become 1 and rcnt SHALL become 0.
REQ-022 No wen or ren SHALL occur in the same cycle as switch_banks.
REQ-023 ren SHALL equal rbusy && (rcnt < BANK_DEPTH) && (!out_valid || out_ready).
REQ-024 radr SHALL equal rcnt[BANK_ADDR_WIDTH-1:0].
REQ-025 On each ren, rcnt SHALL increment by 1.
REQ-026 The buffer read latency is 1 cycle, and the buffer holds rdata while ren=0.
REQ-027 out_valid SHALL be set the cycle after a ren.
REQ-028 out_valid SHALL clear after a handshake (out_valid && out_ready) with no ren in the same cycle; it SHALL otherwise hold.
REQ-029 out_last SHALL be 1 when out_valid=1 and the presented beat came from address BANK_DEPTH-1.
REQ-030 A handshake with out_last=1 SHALL clear rbusy and increment frames_done.
REQ-031 Throughput: with in_valid and out_ready held high, 1 write per cycle and 1 output beat per cycle SHALL be sustained within a frame.
REQ-032 Fill-to-output latency: if the last write is at cycle t with the read side idle, switch_banks SHALL assert at t+1, ren at t+2 and out_valid at t+3.
REQ-033 If the last-beat handshake and the frame-completing wen occur in the same cycle, switch_banks SHALL assert on the next cycle.
REQ-034 While out_ready is held low, ren, radr, out_valid and out_last SHALL stay stable.
REQ-035 wcnt and rcnt SHALL never exceed BANK_DEPTH.
REQ-036 When in_valid is asserted while wfull=1, no write SHALL occur; the producer stalls.

Reset
REQ-037 While rst_n=0, the block SHALL set wcnt=0, rcnt=0, wfull=0, rbusy=0, out_valid=0 and frames_done=0.
REQ-038 Resulting reset output values SHALL be: in_ready=1, wen=in_valid, wadr=0, ren=0, radr=0, switch_banks=0, out_last=0.
REQ-039 Reset asserted mid-frame SHALL discard all partial frames, with no switch_banks pulse or output beat generated afterward from pre-reset data.

Verification (BANK_DEPTH=4)
REQ-040 Scenario: reset, then in_valid=1 for 4 cycles -> wadr 0,1,2,3 with wen=1; then in_ready=0, one switch_banks pulse, and out_valid rises 2 cycles after the pulse.
REQ-041 Scenario: continuous in_valid and out_ready for 3 frames -> beats out in address order 0..3; out_last on every 4th beat; frames_done=2 when the last beat of frame 3 is presented, then 3 after its handshake.
REQ-042 Scenario: out_ready=0 for 5 cycles mid-frame -> out_valid held, no ren, radr stable; resume without loss or duplication.
REQ-043 Scenario: write bank full while the read frame is undrained -> in_ready=0 and no switch_banks until the last-beat handshake; switch_banks asserts the following cycle.
REQ-044 Scenario: rst_n pulsed low after 2 writes -> all outputs at reset values; the next 4 writes start at wadr=0.
REQ-045 Scenario: random in_valid and out_ready over 1000 cycles -> output sequence equals input sequence, and switch_banks never coincides with wen or ren.
